// File: rtl/id_ex_if.sv
// Bundle of decode-side, forwarding and ALU-side signals around the ID/EX register.
interface id_ex_if #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [RIDX-1:0] in_rs1;
    logic [RIDX-1:0] in_rs2;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;
    logic [3:0]      in_alufn;
    logic [RIDX-1:0] in_rd;
    logic            in_rd_we;
    logic            fwd1_we;
    logic [RIDX-1:0] fwd1_rd;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_we;
    logic [RIDX-1:0] fwd2_rd;
    logic [XLEN-1:0] fwd2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [4:0]      out_shamt;
    logic [3:0]      out_alufn;
    logic [XLEN-1:0] out_store_data;
    logic [XLEN-1:0] out_pc;
    logic [RIDX-1:0] out_rd;
    logic            out_rd_we;

    modport master (
        output flush, in_valid, in_pc, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_alufn, in_rd, in_rd_we,
               fwd1_we, fwd1_rd, fwd1_data, fwd2_we, fwd2_rd, fwd2_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_shamt, out_alufn,
               out_store_data, out_pc, out_rd, out_rd_we
    );

    modport slave (
        input  flush, in_valid, in_pc, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_alufn, in_rd, in_rd_we,
               fwd1_we, fwd1_rd, fwd1_data, fwd2_we, fwd2_rd, fwd2_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_shamt, out_alufn,
               out_store_data, out_pc, out_rd, out_rd_we
    );
endinterface

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with operand forwarding that keeps snooping while stalled.
//   state | meaning
//   EMPTY | no instruction held, out_valid low
//   FULL  | instruction held for the ALU, operands tracked against forwarding buses
module id_ex_reg #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input logic   clk,
    input logic   rst_n,
    id_ex_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state, state_nxt;
    logic            in_ready, accept, snoop;
    logic [RIDX-1:0] rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] op1_q, op2_q, imm_q, pc_q;
    logic [XLEN-1:0] op1_nxt, op2_nxt;
    logic            use_imm_q, rd_we_q;
    logic [3:0]      alufn_q;

    // fwd1 (EX/MEM) is younger than fwd2 (MEM/WB), so it wins; x0 is hardwired zero
    function automatic logic [XLEN-1:0] fwd(
        input logic [RIDX-1:0] idx,
        input logic [XLEN-1:0] rf,
        input logic            f1_we,
        input logic [RIDX-1:0] f1_rd,
        input logic [XLEN-1:0] f1_data,
        input logic            f2_we,
        input logic [RIDX-1:0] f2_rd,
        input logic [XLEN-1:0] f2_data
    );
        if (f1_we && f1_rd == idx && idx != '0)
            return f1_data;
        else if (f2_we && f2_rd == idx && idx != '0)
            return f2_data;
        else
            return rf;
    endfunction

    always_comb begin
        in_ready  = (state == EMPTY) || bus.out_ready;
        accept    = bus.in_valid && in_ready && !bus.flush;
        snoop     = (state == FULL) && !bus.out_ready && !bus.flush;
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (bus.flush || (bus.out_ready && !accept)) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        op1_nxt = op1_q;
        op2_nxt = op2_q;
        if (accept) begin
            op1_nxt = fwd(bus.in_rs1, bus.in_rs1_data, bus.fwd1_we, bus.fwd1_rd, bus.fwd1_data,
                          bus.fwd2_we, bus.fwd2_rd, bus.fwd2_data);
            op2_nxt = fwd(bus.in_rs2, bus.in_rs2_data, bus.fwd1_we, bus.fwd1_rd, bus.fwd1_data,
                          bus.fwd2_we, bus.fwd2_rd, bus.fwd2_data);
        end else if (snoop) begin
            op1_nxt = fwd(rs1_q, op1_q, bus.fwd1_we, bus.fwd1_rd, bus.fwd1_data,
                          bus.fwd2_we, bus.fwd2_rd, bus.fwd2_data);
            op2_nxt = fwd(rs2_q, op2_q, bus.fwd1_we, bus.fwd1_rd, bus.fwd1_data,
                          bus.fwd2_we, bus.fwd2_rd, bus.fwd2_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            use_imm_q <= 1'b0;
            rd_we_q   <= 1'b0;
            alufn_q   <= '0;
        end else begin
            op1_q <= op1_nxt;
            op2_q <= op2_nxt;
            if (accept) begin
                rs1_q     <= bus.in_rs1;
                rs2_q     <= bus.in_rs2;
                rd_q      <= bus.in_rd;
                imm_q     <= bus.in_imm;
                pc_q      <= bus.in_pc;
                use_imm_q <= bus.in_use_imm;
                rd_we_q   <= bus.in_rd_we;
                alufn_q   <= bus.in_alufn;
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = (state == FULL);
    assign bus.out_a          = op1_q;
    assign bus.out_b          = use_imm_q ? imm_q : op2_q;
    assign bus.out_shamt      = use_imm_q ? imm_q[4:0] : op2_q[4:0];
    assign bus.out_alufn      = alufn_q;
    assign bus.out_store_data = op2_q;
    assign bus.out_pc         = pc_q;
    assign bus.out_rd         = rd_q;
    assign bus.out_rd_we      = rd_we_q && (state == FULL);
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: handshake, forwarding priority, stall snoop, flush and async reset.
module tb_id_ex_reg;
    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    id_ex_if #(.XLEN(32), .RIDX(5)) bus ();

    id_ex_reg #(.XLEN(32), .RIDX(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.flush = 0; bus.in_valid = 0; bus.in_pc = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
        bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0; bus.in_use_imm = 0;
        bus.in_alufn = 0; bus.in_rd = 0; bus.in_rd_we = 0;
        bus.fwd1_we = 0; bus.fwd1_rd = 0; bus.fwd1_data = 0;
        bus.fwd2_we = 0; bus.fwd2_rd = 0; bus.fwd2_data = 0;
    endtask

    task automatic test_reset();
        #2;
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        vec_cnt++; if ({bus.out_a, bus.out_b, bus.out_store_data, bus.out_pc} !== 128'h0) begin err_cnt++; $display("FAIL reset_data: got a=%h b=%h sd=%h pc=%h want 0", bus.out_a, bus.out_b, bus.out_store_data, bus.out_pc); end
        vec_cnt++; if ({bus.out_shamt, bus.out_alufn, bus.out_rd, bus.out_rd_we} !== 15'h0) begin err_cnt++; $display("FAIL reset_ctrl: got shamt=%h fn=%h rd=%h we=%b want 0", bus.out_shamt, bus.out_alufn, bus.out_rd, bus.out_rd_we); end
        bus.in_valid = 1; bus.in_rs1_data = 32'h77; bus.in_rd_we = 1;
        tick();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_hold_valid: got %b want 0", bus.out_valid); end
        clear_in();
        #2 rst_n = 1;
    endtask

    task automatic test_plain_add();
        bus.in_valid = 1; bus.in_rs1 = 3; bus.in_rs1_data = 5; bus.in_rs2 = 4; bus.in_rs2_data = 7;
        bus.in_alufn = 4'b0000; bus.in_use_imm = 0; bus.in_pc = 32'h100; bus.in_rd = 10; bus.in_rd_we = 1;
        bus.out_ready = 1;
        tick();
        clear_in();
        vec_cnt++; if (bus.out_a !== 32'd5) begin err_cnt++; $display("FAIL add_a: got %h want 5", bus.out_a); end
        vec_cnt++; if (bus.out_b !== 32'd7) begin err_cnt++; $display("FAIL add_b: got %h want 7", bus.out_b); end
        vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL add_valid: got %b want 1", bus.out_valid); end
        vec_cnt++; if (bus.out_store_data !== 32'd7) begin err_cnt++; $display("FAIL add_sd: got %h want 7", bus.out_store_data); end
        vec_cnt++; if (bus.out_shamt !== 5'd7) begin err_cnt++; $display("FAIL add_shamt: got %h want 7", bus.out_shamt); end
        vec_cnt++; if ({bus.out_pc, bus.out_rd, bus.out_rd_we} !== {32'h100, 5'd10, 1'b1}) begin err_cnt++; $display("FAIL add_pass: got pc=%h rd=%0d we=%b want 100/10/1", bus.out_pc, bus.out_rd, bus.out_rd_we); end
        tick();
        vec_cnt++; if ({bus.out_valid, bus.out_rd_we} !== 2'b00) begin err_cnt++; $display("FAIL add_drain: got v=%b we=%b want 0 0", bus.out_valid, bus.out_rd_we); end
    endtask

    task automatic test_fwd_priority();
        bus.out_ready = 1;
        bus.in_valid = 1; bus.in_rs1 = 6; bus.in_rs1_data = 32'h11; bus.in_rs2 = 0; bus.in_rs2_data = 32'h22;
        bus.fwd1_we = 1; bus.fwd1_rd = 6; bus.fwd1_data = 32'hAAAA0000;
        bus.fwd2_we = 1; bus.fwd2_rd = 6; bus.fwd2_data = 32'h1234;
        tick();
        vec_cnt++; if (bus.out_a !== 32'hAAAA0000) begin err_cnt++; $display("FAIL fwd1_wins: got %h want aaaa0000", bus.out_a); end
        vec_cnt++; if (bus.out_store_data !== 32'h22) begin err_cnt++; $display("FAIL fwd_nomatch: got %h want 22", bus.out_store_data); end
        bus.in_rs1 = 0; bus.in_rs1_data = 32'h77;
        bus.fwd1_rd = 0; bus.fwd1_data = 32'hDEAD; bus.fwd2_rd = 0; bus.fwd2_data = 32'hBEEF;
        tick();
        vec_cnt++; if (bus.out_a !== 32'h77) begin err_cnt++; $display("FAIL fwd_x0: got %h want 77", bus.out_a); end
        bus.in_rs1 = 9; bus.in_rs1_data = 32'h5;
        bus.fwd1_rd = 8; bus.fwd1_data = 32'h88; bus.fwd2_rd = 9; bus.fwd2_data = 32'h99;
        tick();
        vec_cnt++; if (bus.out_a !== 32'h99) begin err_cnt++; $display("FAIL fwd2_only: got %h want 99", bus.out_a); end
        vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL fwd_b2b_valid: got %b want 1", bus.out_valid); end
        clear_in();
        tick();
    endtask

    task automatic test_stall_snoop();
        bus.out_ready = 1;
        bus.in_valid = 1; bus.in_rs1 = 1; bus.in_rs1_data = 32'h10; bus.in_rs2 = 2; bus.in_rs2_data = 32'h20;
        bus.in_pc = 32'h200; bus.in_rd = 7; bus.in_rd_we = 1;
        tick();
        bus.in_rs1 = 5; bus.in_rs1_data = 32'h500; bus.in_rs2 = 0; bus.in_rs2_data = 0; bus.in_pc = 32'h300;
        bus.out_ready = 0;
        #1;
        vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_rdy_c1: got %b want 0", bus.in_ready); end
        tick();
        bus.fwd2_we = 1; bus.fwd2_rd = 2; bus.fwd2_data = 32'h55;
        #1;
        vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_rdy_c2: got %b want 0", bus.in_ready); end
        vec_cnt++; if (bus.out_store_data !== 32'h20) begin err_cnt++; $display("FAIL stall_pre_snoop: got %h want 20", bus.out_store_data); end
        tick();
        bus.fwd2_we = 0;
        bus.fwd1_we = 1; bus.fwd1_rd = 1; bus.fwd1_data = 32'h99;
        bus.fwd2_we = 1; bus.fwd2_rd = 1; bus.fwd2_data = 32'h33;
        #1;
        vec_cnt++; if (bus.out_store_data !== 32'h55) begin err_cnt++; $display("FAIL stall_snoop_sd: got %h want 55", bus.out_store_data); end
        vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_rdy_c3: got %b want 0", bus.in_ready); end
        vec_cnt++; if ({bus.out_valid, bus.out_pc, bus.out_a} !== {1'b1, 32'h200, 32'h10}) begin err_cnt++; $display("FAIL stall_hold: got v=%b pc=%h a=%h want 1/200/10", bus.out_valid, bus.out_pc, bus.out_a); end
        tick();
        bus.fwd1_we = 0; bus.fwd2_we = 0;
        vec_cnt++; if (bus.out_a !== 32'h99) begin err_cnt++; $display("FAIL stall_snoop_a: got %h want 99", bus.out_a); end
        vec_cnt++; if (bus.out_store_data !== 32'h55) begin err_cnt++; $display("FAIL stall_sd_keep: got %h want 55", bus.out_store_data); end
        bus.out_ready = 1;
        #1;
        vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL stall_release_rdy: got %b want 1", bus.in_ready); end
        tick();
        clear_in();
        vec_cnt++; if ({bus.out_valid, bus.out_a, bus.out_pc} !== {1'b1, 32'h500, 32'h300}) begin err_cnt++; $display("FAIL stall_next: got v=%b a=%h pc=%h want 1/500/300", bus.out_valid, bus.out_a, bus.out_pc); end
        tick();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_imm_shamt();
        bus.out_ready = 1;
        bus.in_valid = 1; bus.in_use_imm = 1; bus.in_imm = 32'hFFFFFFE3; bus.in_alufn = 4'b1000;
        bus.in_rs2 = 4; bus.in_rs2_data = 32'h40;
        tick();
        vec_cnt++; if (bus.out_b !== 32'hFFFFFFE3) begin err_cnt++; $display("FAIL imm_b: got %h want ffffffe3", bus.out_b); end
        vec_cnt++; if (bus.out_shamt !== 5'd3) begin err_cnt++; $display("FAIL imm_shamt: got %0d want 3", bus.out_shamt); end
        vec_cnt++; if (bus.out_alufn !== 4'b1000) begin err_cnt++; $display("FAIL imm_alufn: got %b want 1000", bus.out_alufn); end
        vec_cnt++; if (bus.out_store_data !== 32'h40) begin err_cnt++; $display("FAIL imm_sd: got %h want 40", bus.out_store_data); end
        bus.in_use_imm = 0; bus.in_rs2_data = 32'h2A; bus.in_alufn = 4'b0101;
        tick();
        clear_in();
        vec_cnt++; if ({bus.out_b, bus.out_shamt, bus.out_alufn} !== {32'h2A, 5'h0A, 4'b0101}) begin err_cnt++; $display("FAIL reg_shamt: got b=%h sh=%h fn=%b want 2a/0a/0101", bus.out_b, bus.out_shamt, bus.out_alufn); end
        tick();
    endtask

    task automatic test_flush();
        bus.out_ready = 1;
        bus.in_valid = 1; bus.in_pc = 32'h400; bus.in_rd = 3; bus.in_rd_we = 1;
        tick();
        vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL flush_pre: got %b want 1", bus.out_valid); end
        bus.flush = 1; bus.in_pc = 32'h404; bus.in_rd = 4;
        #1;
        vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_rdy: got %b want 1", bus.in_ready); end
        tick();
        clear_in();
        vec_cnt++; if ({bus.out_valid, bus.out_rd_we} !== 2'b00) begin err_cnt++; $display("FAIL flush_accept: got v=%b we=%b want 0 0", bus.out_valid, bus.out_rd_we); end
        tick();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_discard: got %b want 0", bus.out_valid); end
        bus.in_valid = 1; bus.in_rd_we = 1;
        tick();
        bus.in_valid = 0; bus.out_ready = 0; bus.flush = 1;
        tick();
        bus.flush = 0;
        vec_cnt++; if ({bus.out_valid, bus.out_rd_we} !== 2'b00) begin err_cnt++; $display("FAIL flush_stall: got v=%b we=%b want 0 0", bus.out_valid, bus.out_rd_we); end
        clear_in();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1;
        bus.in_valid = 1; bus.in_rs1 = 2; bus.in_rs1_data = 32'h1234; bus.in_use_imm = 1; bus.in_imm = 32'h1F;
        bus.in_alufn = 4'b0011; bus.in_pc = 32'h500; bus.in_rd = 9; bus.in_rd_we = 1; bus.in_rs2_data = 32'h6;
        tick();
        clear_in();
        bus.out_ready = 0;
        tick();
        vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL arst_pre: got %b want 1", bus.out_valid); end
        rst_n = 0;
        #1;
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL arst_valid: got %b want 0", bus.out_valid); end
        vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL arst_rdy: got %b want 1", bus.in_ready); end
        vec_cnt++; if ({bus.out_a, bus.out_b, bus.out_store_data, bus.out_pc} !== 128'h0) begin err_cnt++; $display("FAIL arst_data: got a=%h b=%h sd=%h pc=%h want 0", bus.out_a, bus.out_b, bus.out_store_data, bus.out_pc); end
        vec_cnt++; if ({bus.out_shamt, bus.out_alufn, bus.out_rd, bus.out_rd_we} !== 15'h0) begin err_cnt++; $display("FAIL arst_ctrl: got sh=%h fn=%h rd=%h we=%b want 0", bus.out_shamt, bus.out_alufn, bus.out_rd, bus.out_rd_we); end
        #2 rst_n = 1;
        tick();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n = 0;
        clear_in();
        bus.out_ready = 0;
        test_reset();
        test_plain_add();
        test_fwd_priority();
        test_stall_snoop();
        test_imm_shamt();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
